// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory bus between the fetch port
// and the data port. One transaction in flight at a time; handles byte-lane
// steering, write strobes, load extension, misalignment and a hang watchdog.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int DPRIO   = 1,    // 1: dcache wins ties, 0: round-robin on ties
  parameter int TIMEOUT = 255   // wait cycles before abort, 0 disables
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_ena,
  input  logic [31:0] icache_addr,
  output logic        icache_valid,
  output logic [31:0] icache_data,
  input  logic        dcache_r_ena,
  input  logic        dcache_w_ena,
  input  logic        dcache_ext,
  input  logic [1:0]  dcache_width,
  input  logic [31:0] dcache_addr,
  input  logic [31:0] dcache_data_in,
  output logic        dcache_valid,
  output logic [31:0] dcache_data_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  // Counter only needs to reach TIMEOUT-1: the abort fires on the cycle that
  // would make it TIMEOUT.
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] TLIM = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  state_t         r_state, w_state_nxt;
  logic           r_last_d, r_gnt_d, r_ext, r_we;
  logic [1:0]     r_lane, r_width;
  logic [WDW-1:0] r_wdog;
  logic           r_mem_req, r_mem_we, r_ivalid, r_dvalid, r_err;
  logic [31:0]    r_mem_addr, r_mem_wdata, r_idata, r_ddata;
  logic [3:0]     r_mem_wstrb;

  logic        w_d_pend, w_pick_d, w_pick_i, w_misal, w_tout;
  logic [31:0] w_wdata, w_shift, w_load;
  logic [3:0]  w_wstrb;

  // Arbitration, misalignment, watchdog expiry and next state.
  always_comb begin
    w_d_pend    = dcache_r_ena | dcache_w_ena;
    w_pick_d    = w_d_pend && (!icache_ena || (DPRIO != 0) || !r_last_d);
    w_pick_i    = icache_ena && !w_pick_d;
    w_misal     = ((dcache_width == 2'b01) && dcache_addr[0]) ||
                  (dcache_width[1] && (dcache_addr[1:0] != 2'b00));
    w_tout      = (TIMEOUT != 0) && !mem_ready && (r_wdog == TLIM);
    w_state_nxt = r_state;
    case (r_state)
      IDLE:           if (w_pick_d)      w_state_nxt = w_misal ? DONE : BUSY_D;
                      else if (w_pick_i) w_state_nxt = BUSY_I;
      BUSY_I, BUSY_D: if (mem_ready || w_tout) w_state_nxt = DONE;
      DONE:           w_state_nxt = IDLE;
      default:        w_state_nxt = IDLE;
    endcase
  end

  // Store lane replication and byte strobes from the live request.
  always_comb begin
    w_wdata = dcache_data_in;
    w_wstrb = 4'b1111;
    case (dcache_width)
      2'b00: begin w_wdata = {4{dcache_data_in[7:0]}};  w_wstrb = 4'b0001 << dcache_addr[1:0]; end
      2'b01: begin w_wdata = {2{dcache_data_in[15:0]}}; w_wstrb = 4'b0011 << dcache_addr[1:0]; end
      default: ;
    endcase
  end

  // Load alignment and sign/zero extension from the registered attributes.
  always_comb begin
    w_shift = mem_rdata >> {r_lane, 3'b000};
    case (r_width)
      2'b00:   w_load = {{24{r_ext & w_shift[7]}},  w_shift[7:0]};
      2'b01:   w_load = {{16{r_ext & w_shift[15]}}, w_shift[15:0]};
      default: w_load = w_shift;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Datapath: issue on grant, capture or abort in BUSY, pulse and retire in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_d <= 1'b0; r_gnt_d <= 1'b0; r_ext <= 1'b0; r_we <= 1'b0;
      r_lane <= '0; r_width <= '0; r_wdog <= '0;
      r_mem_req <= 1'b0; r_mem_we <= 1'b0; r_mem_addr <= '0;
      r_mem_wdata <= '0; r_mem_wstrb <= '0;
      r_ivalid <= 1'b0; r_idata <= '0; r_dvalid <= 1'b0; r_ddata <= '0; r_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_d) begin
            r_gnt_d <= 1'b1;
            r_lane  <= dcache_addr[1:0];
            r_width <= dcache_width;
            r_ext   <= dcache_ext;
            r_we    <= dcache_w_ena;
            if (w_misal) begin
              // Never touches memory; reported straight from DONE.
              r_dvalid <= 1'b1;
              r_err    <= 1'b1;
              r_ddata  <= '0;
            end else begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= dcache_w_ena;
              r_mem_addr  <= dcache_addr & WORD_MASK;
              r_mem_wdata <= dcache_w_ena ? w_wdata : '0;
              r_mem_wstrb <= dcache_w_ena ? w_wstrb : '0;
            end
          end else if (w_pick_i) begin
            r_gnt_d     <= 1'b0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= icache_addr & WORD_MASK;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready || w_tout) begin
            r_mem_req <= 1'b0; r_mem_we <= 1'b0; r_mem_addr <= '0;
            r_mem_wdata <= '0; r_mem_wstrb <= '0;
            r_err <= !mem_ready;
            if (r_gnt_d) begin
              r_dvalid <= 1'b1;
              r_ddata  <= (mem_ready && !r_we) ? w_load : '0;
            end else begin
              r_ivalid <= 1'b1;
              r_idata  <= mem_ready ? mem_rdata : '0;
            end
          end else begin
            r_wdog <= r_wdog + WDW'(1);
          end
        end
        DONE: begin
          r_ivalid <= 1'b0; r_idata <= '0;
          r_dvalid <= 1'b0; r_ddata <= '0;
          r_err    <= 1'b0;
          r_last_d <= r_gnt_d;
          r_wdog   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign icache_valid    = r_ivalid;
  assign icache_data     = r_idata;
  assign dcache_valid    = r_dvalid;
  assign dcache_data_out = r_ddata;
  assign mem_req         = r_mem_req;
  assign mem_we          = r_mem_we;
  assign mem_addr        = r_mem_addr;
  assign mem_wdata       = r_mem_wdata;
  assign mem_wstrb       = r_mem_wstrb;
  assign err             = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (round-robin ties, 4-cycle watchdog).
// Cycle 0 is the cycle in which a request is first visible to the arbiter.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  logic        clk, rst;
  logic        icache_ena, icache_valid;
  logic [31:0] icache_addr, icache_data;
  logic        dcache_r_ena, dcache_w_ena, dcache_ext, dcache_valid;
  logic [1:0]  dcache_width;
  logic [31:0] dcache_addr, dcache_data_in, dcache_data_out;
  logic        mem_req, mem_we, mem_ready, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int checks = 0;
  int errors = 0;

  // memory responder: ready after wait_n wait cycles while resp_en is set
  int          wait_n = 0;
  int          cnt = 0;
  logic        resp_en = 1'b1, auto_ready = 1'b0, man_ready = 1'b0;
  logic [31:0] rd_v = '0;
  assign mem_ready = resp_en ? auto_ready : man_ready;
  assign mem_rdata = rd_v;

  mem_port_arbiter #(.DPRIO(0), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .icache_ena(icache_ena), .icache_addr(icache_addr),
    .icache_valid(icache_valid), .icache_data(icache_data),
    .dcache_r_ena(dcache_r_ena), .dcache_w_ena(dcache_w_ena),
    .dcache_ext(dcache_ext), .dcache_width(dcache_width),
    .dcache_addr(dcache_addr), .dcache_data_in(dcache_data_in),
    .dcache_valid(dcache_valid), .dcache_data_out(dcache_data_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (mem_req) begin
        if (cnt >= wait_n) begin auto_ready = 1'b1; cnt = 0; end
        else begin auto_ready = 1'b0; cnt++; end
      end else begin
        auto_ready = 1'b0; cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running, want done");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic drop_all();
    icache_ena = 0; dcache_r_ena = 0; dcache_w_ena = 0;
  endtask

  task automatic test_reset();
    rst = 1; drop_all(); icache_addr = 0; dcache_ext = 0; dcache_width = 0;
    dcache_addr = 0; dcache_data_in = 0;
    tick(); tick();
    checks++; if ({mem_req, mem_we, icache_valid, dcache_valid, err} !== 5'b0) begin errors++; $display("FAIL reset_ctl: got %b want 00000", {mem_req, mem_we, icache_valid, dcache_valid, err}); end
    checks++; if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin errors++; $display("FAIL reset_mem: got %h want 0", {mem_addr, mem_wdata, mem_wstrb}); end
    checks++; if ({icache_data, dcache_data_out} !== 64'h0) begin errors++; $display("FAIL reset_data: got %h want 0", {icache_data, dcache_data_out}); end
    rst = 0;
    tick();
  endtask

  task automatic test_fetch(input logic [31:0] a, input logic [31:0] d);
    resp_en = 1; wait_n = 0; rd_v = d;
    icache_ena = 1; icache_addr = a;
    tick();
    checks++; if ({mem_req, mem_we, mem_wstrb, mem_addr} !== {1'b1, 1'b0, 4'b0, a}) begin errors++; $display("FAIL fetch_c1: got req=%b we=%b strb=%b addr=%h want 1 0 0000 %h", mem_req, mem_we, mem_wstrb, mem_addr, a); end
    checks++; if (icache_valid !== 1'b0) begin errors++; $display("FAIL fetch_early_valid: got %b want 0", icache_valid); end
    tick();
    checks++; if ({icache_valid, icache_data, dcache_valid, err} !== {1'b1, d, 1'b0, 1'b0}) begin errors++; $display("FAIL fetch_c2: got v=%b d=%h dv=%b err=%b want 1 %h 0 0", icache_valid, icache_data, dcache_valid, err, d); end
    drop_all();
    tick();
    checks++; if ({icache_valid, mem_req} !== 2'b00) begin errors++; $display("FAIL fetch_c3: got v=%b req=%b want 0 0", icache_valid, mem_req); end
  endtask

  task automatic test_tie();
    // last grant is I (previous fetch), so D wins; 3 wait cycles each
    resp_en = 1; wait_n = 3; rd_v = 32'h1122_3344;
    icache_ena = 1; icache_addr = 32'h500;
    dcache_r_ena = 1; dcache_width = 2'b10; dcache_ext = 0; dcache_addr = 32'h600;
    tick();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h600}) begin errors++; $display("FAIL tie_first_d: got req=%b addr=%h want 1 00000600", mem_req, mem_addr); end
    tick(); tick(); tick();
    checks++; if ({mem_req, dcache_valid, icache_valid} !== 3'b100) begin errors++; $display("FAIL tie_wait: got %b want 100", {mem_req, dcache_valid, icache_valid}); end
    tick();
    checks++; if ({dcache_valid, dcache_data_out, icache_valid} !== {1'b1, 32'h1122_3344, 1'b0}) begin errors++; $display("FAIL tie_d_done: got v=%b d=%h iv=%b want 1 11223344 0", dcache_valid, dcache_data_out, icache_valid); end
    dcache_r_ena = 0; rd_v = 32'hCAFE_F00D;
    tick();
    checks++; if (dcache_valid !== 1'b0) begin errors++; $display("FAIL tie_d_one_cycle: got %b want 0", dcache_valid); end
    tick();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h500}) begin errors++; $display("FAIL tie_then_i: got req=%b addr=%h want 1 00000500", mem_req, mem_addr); end
    tick(); tick(); tick(); tick();
    checks++; if ({icache_valid, icache_data, dcache_valid} !== {1'b1, 32'hCAFE_F00D, 1'b0}) begin errors++; $display("FAIL tie_i_done: got v=%b d=%h dv=%b want 1 cafef00d 0", icache_valid, icache_data, dcache_valid); end
    icache_ena = 0;
    tick();
    checks++; if (icache_valid !== 1'b0) begin errors++; $display("FAIL tie_i_one_cycle: got %b want 0", icache_valid); end
    // second tie: last grant is now I, so D again
    wait_n = 0; rd_v = 32'h0000_0042;
    icache_ena = 1; icache_addr = 32'h504; dcache_r_ena = 1; dcache_addr = 32'h604;
    tick();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h604}) begin errors++; $display("FAIL tie2_d: got req=%b addr=%h want 1 00000604", mem_req, mem_addr); end
    tick();
    checks++; if ({dcache_valid, dcache_data_out} !== {1'b1, 32'h42}) begin errors++; $display("FAIL tie2_d_done: got v=%b d=%h want 1 00000042", dcache_valid, dcache_data_out); end
    dcache_r_ena = 0;
    tick(); tick();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h504}) begin errors++; $display("FAIL tie2_i: got req=%b addr=%h want 1 00000504", mem_req, mem_addr); end
    tick();
    checks++; if (icache_valid !== 1'b1) begin errors++; $display("FAIL tie2_i_done: got %b want 1", icache_valid); end
    icache_ena = 0;
    tick();
  endtask

  task automatic test_loads();
    logic [31:0] ad [7] = '{32'h203, 32'h203, 32'h202, 32'h200, 32'h204, 32'h201, 32'h208};
    logic [1:0]  wd [7] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 2'b11};
    logic        ex [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] rd [7] = '{32'h80FF1234, 32'h80FF1234, 32'h80FF1234, 32'h80FF1234,
                            32'h80FF1234, 32'h80FF1234, 32'hDEADBEEF};
    logic [31:0] xp [7] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00001234,
                            32'h80FF1234, 32'h00000012, 32'hDEADBEEF};
    resp_en = 1; wait_n = 0;
    for (int i = 0; i < 7; i++) begin
      rd_v = rd[i];
      dcache_r_ena = 1; dcache_addr = ad[i]; dcache_width = wd[i]; dcache_ext = ex[i];
      tick();
      checks++; if ({mem_req, mem_we, mem_wstrb, mem_addr} !== {1'b1, 1'b0, 4'b0, ad[i] & 32'hFFFFFFFC}) begin errors++; $display("FAIL load%0d_issue: got req=%b we=%b strb=%b addr=%h", i, mem_req, mem_we, mem_wstrb, mem_addr); end
      tick();
      checks++; if ({dcache_valid, dcache_data_out, err} !== {1'b1, xp[i], 1'b0}) begin errors++; $display("FAIL load%0d_data: got v=%b d=%h err=%b want 1 %h 0", i, dcache_valid, dcache_data_out, err, xp[i]); end
      drop_all();
      tick();
    end
  endtask

  task automatic test_stores();
    logic [31:0] ad [4] = '{32'h402, 32'h401, 32'h40C, 32'h410};
    logic [1:0]  wd [4] = '{2'b01, 2'b00, 2'b10, 2'b00};
    logic [31:0] di [4] = '{32'hABCD1234, 32'h0000005A, 32'hCAFEBABE, 32'h12345677};
    logic        rb [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] xw [4] = '{32'h12341234, 32'h5A5A5A5A, 32'hCAFEBABE, 32'h77777777};
    logic [3:0]  xs [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b0001};
    resp_en = 1; wait_n = 0; rd_v = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      dcache_w_ena = 1; dcache_r_ena = rb[i]; dcache_addr = ad[i]; dcache_width = wd[i];
      dcache_data_in = di[i]; dcache_ext = 1;
      tick();
      checks++; if ({mem_req, mem_we, mem_wstrb, mem_wdata, mem_addr} !== {1'b1, 1'b1, xs[i], xw[i], ad[i] & 32'hFFFFFFFC}) begin errors++; $display("FAIL store%0d_issue: got we=%b strb=%b wdata=%h addr=%h want 1 %b %h", i, mem_we, mem_wstrb, mem_wdata, mem_addr, xs[i], xw[i]); end
      tick();
      checks++; if ({dcache_valid, dcache_data_out} !== {1'b1, 32'h0}) begin errors++; $display("FAIL store%0d_done: got v=%b d=%h want 1 00000000", i, dcache_valid, dcache_data_out); end
      drop_all();
      tick();
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] ad [2] = '{32'h301, 32'h303};
    logic [1:0]  wd [2] = '{2'b10, 2'b01};
    for (int i = 0; i < 2; i++) begin
      dcache_r_ena = 1; dcache_addr = ad[i]; dcache_width = wd[i]; dcache_ext = 1;
      tick();
      // no memory phase: DONE follows IDLE directly
      checks++; if ({mem_req, dcache_valid, err, dcache_data_out} !== {3'b011, 32'h0}) begin errors++; $display("FAIL misal%0d: got req=%b v=%b err=%b d=%h want 0 1 1 0", i, mem_req, dcache_valid, err, dcache_data_out); end
      drop_all();
      tick();
      checks++; if ({mem_req, dcache_valid, err} !== 3'b000) begin errors++; $display("FAIL misal%0d_after: got %b want 000", i, {mem_req, dcache_valid, err}); end
    end
  endtask

  task automatic test_timeout();
    resp_en = 0; man_ready = 0;
    dcache_r_ena = 1; dcache_addr = 32'h700; dcache_width = 2'b10;
    tick(); tick(); tick(); tick();
    checks++; if ({mem_req, dcache_valid} !== 2'b10) begin errors++; $display("FAIL tout_wait4: got %b want 10", {mem_req, dcache_valid}); end
    tick();
    checks++; if ({mem_req, dcache_valid, err, dcache_data_out} !== {3'b011, 32'h0}) begin errors++; $display("FAIL tout_abort: got req=%b v=%b err=%b d=%h want 0 1 1 0", mem_req, dcache_valid, err, dcache_data_out); end
    drop_all();
    tick();
    checks++; if ({dcache_valid, err} !== 2'b00) begin errors++; $display("FAIL tout_after: got %b want 00", {dcache_valid, err}); end
    resp_en = 1;
  endtask

  task automatic test_reset_mid();
    resp_en = 0; man_ready = 0;
    dcache_r_ena = 1; dcache_addr = 32'h800; dcache_width = 2'b10;
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_busy: got %b want 1", mem_req); end
    rst = 1; drop_all();
    tick();
    checks++; if ({mem_req, mem_we, mem_addr, mem_wstrb, dcache_valid, icache_valid, err} !== 41'h0) begin errors++; $display("FAIL rstmid_clear: got req=%b addr=%h v=%b err=%b want all 0", mem_req, mem_addr, dcache_valid, err); end
    rst = 0; man_ready = 1;
    tick();
    checks++; if ({mem_req, dcache_valid, icache_valid, err} !== 4'b0) begin errors++; $display("FAIL rstmid_late_ready: got %b want 0000", {mem_req, dcache_valid, icache_valid, err}); end
    tick();
    checks++; if ({dcache_valid, icache_valid} !== 2'b0) begin errors++; $display("FAIL rstmid_late_ready2: got %b want 00", {dcache_valid, icache_valid}); end
    man_ready = 0;
    test_fetch(32'h104, 32'h0000_0093);
  endtask

  initial begin
    rst = 1; icache_ena = 0; dcache_r_ena = 0; dcache_w_ena = 0;
    test_reset();
    test_fetch(32'h100, 32'h0000_0013);
    test_tie();
    test_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
